channel_cgra_data_32_1_1_latency_1: RTL and testbench

//   Single-hop CGRA interconnect channel carrying one CGRAData_32_1_1 token per transfer.

---
 rtl/cgra_pkg.sv | 29 ++
 rtl/normal_queue_2.sv | 57 +++++
 rtl/channel_cgra_data_32_1_1_latency_1.sv | 42 ++++
 tb/tb_channel_cgra_data_32_1_1_latency_1.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA types: data tokens, predicate tokens and tile configuration words.
package cgra_pkg;

    localparam int DATA_W = 34;

    // Channel token: 32-bit payload plus the predicate and bypass flags.
    typedef struct packed {
        logic [31:0] payload;
        logic        predicate;
        logic        bypass;
    } CGRAData_32_1_1;

    // Predicate-only token.
    typedef struct packed {
        logic payload;
        logic predicate;
    } CGRAData_1_1;

    // Tile configuration word: 6-bit opcode, predicate flag, 4 FU input selects,
    // 6 crossbar output routes and 8 routing-predicate enables.
    typedef struct packed {
        logic [5:0]      ctrl;
        logic            predicate;
        logic [3:0][2:0] fu_in;
        logic [5:0][2:0] outport;
        logic [7:0]      routing_predicate_in;
    } CGRAConfig_6_4_6_8;

endpackage

// File: rtl/normal_queue_2.sv
// Two-entry registered FIFO with en/rdy on both sides and an occupancy output.
// No bypass: a token is visible at the head one cycle after it is written.
module normal_queue_2
    import cgra_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enq_en,
    input  logic [DATA_W-1:0] i_enq_msg,
    output logic              o_enq_rdy,
    output logic              o_deq_en,
    input  logic              i_deq_rdy,
    output logic [DATA_W-1:0] o_deq_msg,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_entry [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;

    logic              w_enq;
    logic              w_deq;
    logic [1:0]        w_count_next;

    // Handshake decode; readiness depends only on stored occupancy.
    always_comb begin
        o_enq_rdy    = (r_count < 2'd2);
        o_deq_en     = i_deq_rdy & (r_count != 2'd0);
        w_enq        = i_enq_en & o_enq_rdy;
        w_deq        = o_deq_en;
        w_count_next = r_count + {1'b0, w_enq} - {1'b0, w_deq};
        o_deq_msg    = r_entry[r_head];
        o_count      = r_count;
    end

    // Storage, pointer and occupancy update; an enqueue while full is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_enq) begin
                r_entry[r_tail] <= i_enq_msg;
                r_tail          <= ~r_tail;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/channel_cgra_data_32_1_1_latency_1.sv
// Single-hop CGRA channel: one-cycle registered hop built on a 2-entry FIFO.
// Handshake outputs and the data bus are forced low while reset is held.
module channel_cgra_data_32_1_1_latency_1
    import cgra_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              recv__en,
    input  logic [DATA_W-1:0] recv__msg,
    output logic              recv__rdy,
    output logic              send__en,
    output logic [DATA_W-1:0] send__msg,
    input  logic              send__rdy,
    output logic [1:0]        count
);

    logic              w_enq_rdy;
    logic              w_deq_en;
    logic [DATA_W-1:0] w_deq_msg;
    logic [1:0]        w_count;

    normal_queue_2 u_queue (
        .clk       (clk),
        .rst       (reset),
        .i_enq_en  (recv__en),
        .i_enq_msg (recv__msg),
        .o_enq_rdy (w_enq_rdy),
        .o_deq_en  (w_deq_en),
        .i_deq_rdy (send__rdy),
        .o_deq_msg (w_deq_msg),
        .o_count   (w_count)
    );

    // Reset gating of the externally visible handshake and data.
    always_comb begin
        recv__rdy = w_enq_rdy & ~reset;
        send__en  = w_deq_en & ~reset;
        send__msg = reset ? '0 : w_deq_msg;
        count     = w_count;
    end

endmodule

// File: tb/tb_channel_cgra_data_32_1_1_latency_1.sv
module tb_channel_cgra_data_32_1_1_latency_1;

    logic        clk;
    logic        reset;
    logic        recv__en;
    logic [33:0] recv__msg;
    logic        recv__rdy;
    logic        send__en;
    logic [33:0] send__msg;
    logic        send__rdy;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [33:0] sb[$];

    channel_cgra_data_32_1_1_latency_1 dut (
        .clk       (clk),
        .reset     (reset),
        .recv__en  (recv__en),
        .recv__msg (recv__msg),
        .recv__rdy (recv__rdy),
        .send__en  (send__en),
        .send__msg (send__msg),
        .send__rdy (send__rdy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        en;
        logic [33:0] msg;
        logic        srdy;
        logic        exp_rdy;
        logic        exp_sen;
        logic [1:0]  exp_cnt;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [33:0] msg, input logic srdy,
                                input logic rdy, input logic sen, input logic [1:0] cnt);
        vec_t v;
        v.en = en; v.msg = msg; v.srdy = srdy;
        v.exp_rdy = rdy; v.exp_sen = sen; v.exp_cnt = cnt;
        return v;
    endfunction

    // Compare the delivered token against the scoreboard head.
    task automatic chk_send(input string name);
        logic [33:0] e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: act=%h exp=<empty scoreboard>", name, send__msg);
        end else begin
            e = sb.pop_front();
            chk(name, send__msg, e);
        end
    endtask

    localparam logic [33:0] T1  = {32'hECEBECEB, 1'b1, 1'b1};
    localparam logic [33:0] T2  = {32'hAAAAAAAA, 1'b1, 1'b1};
    localparam logic [33:0] T3  = {32'h11111111, 1'b0, 1'b0};
    localparam logic [33:0] T4  = {32'h22222222, 1'b1, 1'b0};
    localparam logic [33:0] T5  = {32'h33333333, 1'b0, 1'b1};
    localparam logic [33:0] F0  = {32'h00000000, 1'b0, 1'b1};
    localparam logic [33:0] F1  = {32'hFFFFFFFF, 1'b0, 1'b1};

    initial begin
        // single token
        vt[0]  = mk(1, T1, 1, 1, 0, 0);
        vt[1]  = mk(0, '0, 1, 1, 1, 1);
        vt[2]  = mk(0, '0, 1, 1, 0, 0);
        // back-to-back
        vt[3]  = mk(1, T1, 1, 1, 0, 0);
        vt[4]  = mk(1, T2, 1, 1, 1, 1);
        vt[5]  = mk(0, '0, 1, 1, 1, 1);
        vt[6]  = mk(0, '0, 1, 1, 0, 0);
        // backpressure: third offer refused
        vt[7]  = mk(1, T3, 0, 1, 0, 0);
        vt[8]  = mk(1, T4, 0, 1, 0, 1);
        vt[9]  = mk(1, T5, 0, 0, 0, 2);
        vt[10] = mk(0, '0, 1, 0, 1, 2);
        vt[11] = mk(0, '0, 1, 1, 1, 1);
        vt[12] = mk(0, '0, 1, 1, 0, 0);
        // streaming at count=1, pointers wrap several times
        vt[13] = mk(1, 34'h0_0000_1234, 1, 1, 0, 0);
        vt[14] = mk(1, 34'h1_2345_6789, 1, 1, 1, 1);
        vt[15] = mk(1, 34'h2_DEAD_BEEF, 1, 1, 1, 1);
        vt[16] = mk(1, 34'h3_0F0F_0F0F, 1, 1, 1, 1);
        vt[17] = mk(1, 34'h1_5555_5555, 1, 1, 1, 1);
        vt[18] = mk(1, 34'h2_ABCD_EF01, 1, 1, 1, 1);
        vt[19] = mk(0, '0, 1, 1, 1, 1);
        vt[20] = mk(0, '0, 1, 1, 0, 0);
        // field integrity
        vt[21] = mk(1, F0, 0, 1, 0, 0);
        vt[22] = mk(1, F1, 0, 1, 0, 1);
        vt[23] = mk(0, '0, 1, 0, 1, 2);
        vt[24] = mk(0, '0, 1, 1, 1, 1);
        vt[25] = mk(0, '0, 1, 1, 0, 0);

        reset = 1'b1; recv__en = 1'b0; recv__msg = '0; send__rdy = 1'b1;
        #1;
        chk("por_rdy",   {33'b0, recv__rdy}, 34'd0);
        chk("por_sen",   {33'b0, send__en},  34'd0);
        chk("por_msg",   send__msg,          34'd0);
        chk("por_count", {32'b0, count},     34'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("por_rdy_after", {33'b0, recv__rdy}, 34'd1);
        chk("por_msg_after", send__msg,          34'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 26; i++) begin
            recv__en  = vt[i].en;
            recv__msg = vt[i].msg;
            send__rdy = vt[i].srdy;
            if (vt[i].en && vt[i].exp_rdy) sb.push_back(vt[i].msg);
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i),   {33'b0, recv__rdy}, {33'b0, vt[i].exp_rdy});
            chk($sformatf("v%0d_sen", i),   {33'b0, send__en},  {33'b0, vt[i].exp_sen});
            chk($sformatf("v%0d_count", i), {32'b0, count},     {32'b0, vt[i].exp_cnt});
            if (vt[i].exp_sen) chk_send($sformatf("v%0d_msg", i));
            @(posedge clk); #1;
        end
        recv__en = 1'b0;
        chk("sb_drained", 34'(sb.size()), 34'd0);

        // mid-stream reset with two tokens held
        send__rdy = 1'b0;
        recv__en = 1'b1; recv__msg = T1;
        @(posedge clk); #1;
        recv__msg = T2;
        @(posedge clk); #1;
        recv__en = 1'b0;
        @(negedge clk);
        chk("full_count", {32'b0, count}, 34'd2);
        send__rdy = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", {32'b0, count},     34'd0);
        chk("rst_rdy",   {33'b0, recv__rdy}, 34'd0);
        chk("rst_sen",   {33'b0, send__en},  34'd0);
        chk("rst_msg",   send__msg,          34'd0);
        sb.delete();
        recv__en = 1'b1; recv__msg = T5;
        @(posedge clk); #1;
        chk("rst_ignores_en", {32'b0, count}, 34'd0);
        recv__en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdy_after", {33'b0, recv__rdy}, 34'd1);
        chk("rst_msg_after", send__msg,          34'd0);
        @(posedge clk); #1;

        // fresh token after reset
        recv__en = 1'b1; recv__msg = T4;
        @(posedge clk); #1;
        recv__en = 1'b0;
        @(negedge clk);
        chk("post_rst_sen",   {33'b0, send__en}, 34'd1);
        chk("post_rst_msg",   send__msg,         T4);
        chk("post_rst_count", {32'b0, count},    34'd1);
        @(posedge clk); #1;
        chk("post_rst_empty", {32'b0, count},    34'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
